// File: rtl/std_spram_pkg.sv
// Shared types and parameter helpers for the banked single-port SRAM controller.
package std_spram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned mask_w(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/std_spram256x128_b16.sv
// Behavioural stand-in for the 256x128 byte-maskable SRAM hard macro.
module std_spram256x128_b16 (
  input  logic         CLK,
  input  logic         CEB,
  input  logic         WEB,
  input  logic [7:0]   A,
  input  logic [127:0] D,
  input  logic [15:0]  BWEB,
  output logic [127:0] Q
);

  std_spram_model #(
    .DEPTH (256),
    .ADDR_W(8),
    .DW    (128),
    .MW    (16)
  ) u_model (
    .CLK (CLK),
    .CEB (CEB),
    .WEB (WEB),
    .A   (A),
    .D   (D),
    .BWEB(BWEB),
    .Q   (Q)
  );

endmodule

// File: rtl/std_spram_bank.sv
// One bank: request-to-pin translation, clear-write mux, read tracking and optional output register.
module std_spram_bank
  import std_spram_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned BANK_DW = 128,
  parameter int unsigned MASK_W  = 16,
  parameter int unsigned OUT_REG = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic [ADDR_W-1:0]  i_clr_addr,
  input  logic               i_valid,
  input  logic               i_ready,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [BANK_DW-1:0] i_wdata,
  input  logic [MASK_W-1:0]  i_wmask,
  output logic               o_rvalid,
  output logic [BANK_DW-1:0] o_rdata
);

  logic               w_acc;
  logic               w_ceb;
  logic               w_web;
  logic [ADDR_W-1:0]  w_a;
  logic [BANK_DW-1:0] w_d;
  logic [MASK_W-1:0]  w_bweb;
  logic [BANK_DW-1:0] w_q;
  logic               r_pend;

  // A write with no byte enabled never touches the macro.
  always_comb begin
    w_acc  = i_valid & i_ready;
    w_ceb  = ~(w_acc & (~i_we | (|i_wmask)));
    w_web  = ~i_we;
    w_a    = i_addr;
    w_d    = i_wdata;
    w_bweb = ~i_wmask;
    if (i_clr) begin
      w_ceb  = 1'b0;
      w_web  = 1'b0;
      w_a    = i_clr_addr;
      w_d    = '0;
      w_bweb = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_pend <= 1'b0;
    else       r_pend <= w_acc & ~i_we;
  end

  if (DEPTH == 256 && ADDR_W == 8 && BANK_DW == 128 && MASK_W == 16) begin : g_macro
    std_spram256x128_b16 u_mem (
      .CLK (i_clk), .CEB(w_ceb), .WEB(w_web), .A(w_a), .D(w_d), .BWEB(w_bweb), .Q(w_q)
    );
  end else begin : g_model
    std_spram_model #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DW(BANK_DW), .MW(MASK_W)
    ) u_mem (
      .CLK (i_clk), .CEB(w_ceb), .WEB(w_web), .A(w_a), .D(w_d), .BWEB(w_bweb), .Q(w_q)
    );
  end

  if (OUT_REG != 0) begin : g_oreg
    logic               r_rvalid;
    logic [BANK_DW-1:0] r_rdata;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_rvalid <= 1'b0;
        r_rdata  <= '0;
      end else begin
        r_rvalid <= r_pend;
        if (r_pend) r_rdata <= w_q;
      end
    end

    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;
  end else begin : g_direct
    assign o_rvalid = r_pend;
    assign o_rdata  = w_q;
  end

endmodule

// File: rtl/std_spram_model.sv
// Behavioural single-port SRAM with active-low chip/write/byte enables and registered Q.
module std_spram_model #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DW     = 128,
  parameter int unsigned MW     = 16
) (
  input  logic              CLK,
  input  logic              CEB,
  input  logic              WEB,
  input  logic [ADDR_W-1:0] A,
  input  logic [DW-1:0]     D,
  input  logic [MW-1:0]     BWEB,
  output logic [DW-1:0]     Q
);

  logic [DW-1:0] r_mem [DEPTH];

  // Q only changes on a read, so it holds across later writes.
  always_ff @(posedge CLK) begin
    if (!CEB) begin
      if (!WEB) begin
        for (int i = 0; i < int'(MW); i++) begin
          if (!BWEB[i]) r_mem[A][i*8 +: 8] <= D[i*8 +: 8];
        end
      end else begin
        Q <= r_mem[A];
      end
    end
  end

endmodule

// File: rtl/std_spram_banked_ctrl.sv
// N-bank single-port SRAM controller: INIT/RUN sequencing, zero-clear counter and bank array.
module std_spram_banked_ctrl
  import std_spram_pkg::*;
#(
  parameter int unsigned NUM_BANK   = 2,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_W     = clog2(DEPTH),
  parameter int unsigned BANK_DW    = 128,
  parameter int unsigned MASK_W     = mask_w(BANK_DW),
  parameter int unsigned OUT_REG    = 1,
  parameter int unsigned CLR_ON_RST = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         clr_req,
  output logic                         init_done,
  input  logic [NUM_BANK-1:0]          req_valid,
  output logic [NUM_BANK-1:0]          req_ready,
  input  logic [NUM_BANK-1:0]          req_we,
  input  logic [NUM_BANK*ADDR_W-1:0]   req_addr,
  input  logic [NUM_BANK*BANK_DW-1:0]  req_wdata,
  input  logic [NUM_BANK*MASK_W-1:0]   req_wmask,
  output logic [NUM_BANK-1:0]          rvalid,
  output logic [NUM_BANK*BANK_DW-1:0]  rdata
);

  localparam state_e ST_RST = (CLR_ON_RST != 0) ? ST_INIT : ST_RUN;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic                w_last;
  logic                w_clr;
  logic                w_run_nxt;
  logic [NUM_BANK-1:0] r_ready;
  logic                r_init_done;

  assign w_last = (r_clr_cnt == ADDR_W'(DEPTH - 1));
  assign w_clr  = (r_state == ST_INIT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_RST;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (w_last)  w_state_nxt = ST_RUN;
      ST_RUN:  if (clr_req) w_state_nxt = ST_INIT;
      default: w_state_nxt = ST_RST;
    endcase
  end

  always_comb begin
    w_run_nxt = (w_state_nxt == ST_RUN);
  end

  // Handshake outputs follow the state register one-for-one, never req_valid.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ready     <= {NUM_BANK{ST_RST == ST_RUN}};
      r_init_done <= (ST_RST == ST_RUN);
    end else begin
      r_ready     <= {NUM_BANK{w_run_nxt}};
      r_init_done <= w_run_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                        r_clr_cnt <= '0;
    else if (w_clr && !w_last)      r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
    else                            r_clr_cnt <= '0;
  end

  assign req_ready = r_ready;
  assign init_done = r_init_done;

  for (genvar b = 0; b < int'(NUM_BANK); b++) begin : g_bank
    std_spram_bank #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .BANK_DW(BANK_DW),
      .MASK_W (MASK_W),
      .OUT_REG(OUT_REG)
    ) u_bank (
      .i_clk     (CLK),
      .i_rst     (RST),
      .i_clr     (w_clr),
      .i_clr_addr(r_clr_cnt),
      .i_valid   (req_valid[b]),
      .i_ready   (r_ready[b]),
      .i_we      (req_we[b]),
      .i_addr    (req_addr[b*ADDR_W +: ADDR_W]),
      .i_wdata   (req_wdata[b*BANK_DW +: BANK_DW]),
      .i_wmask   (req_wmask[b*MASK_W +: MASK_W]),
      .o_rvalid  (rvalid[b]),
      .o_rdata   (rdata[b*BANK_DW +: BANK_DW])
    );
  end

endmodule

// File: tb/tb_std_spram_banked_ctrl.sv
// Scoreboard bench: two controllers (OUT_REG=1 and OUT_REG=0) share stimulus; a monitor checks rvalid timing and data.
module tb_std_spram_banked_ctrl;

  localparam int NB = 2;
  localparam int AW = 8;
  localparam int DW = 128;
  localparam int MW = 16;
  localparam int DEPTH = 256;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              clr_req = 1'b0;
  logic [NB-1:0]     req_valid = '0;
  logic [NB-1:0]     req_we = '0;
  logic [NB*AW-1:0]  req_addr = '0;
  logic [NB*DW-1:0]  req_wdata = '0;
  logic [NB*MW-1:0]  req_wmask = '0;

  logic              init_done1, init_done0;
  logic [NB-1:0]     req_ready1, req_ready0;
  logic [NB-1:0]     rvalid1, rvalid0;
  logic [NB*DW-1:0]  rdata1, rdata0;

  std_spram_banked_ctrl #(.OUT_REG(1)) dut (
    .CLK(CLK), .RST(RST), .clr_req(clr_req), .init_done(init_done1),
    .req_valid(req_valid), .req_ready(req_ready1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rvalid(rvalid1), .rdata(rdata1)
  );

  std_spram_banked_ctrl #(.OUT_REG(0)) dut0 (
    .CLK(CLK), .RST(RST), .clr_req(clr_req), .init_done(init_done0),
    .req_valid(req_valid), .req_ready(req_ready0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rvalid(rvalid0), .rdata(rdata0)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int            n_chk = 0;
  int            n_fail = 0;
  int            rv_cnt [4];
  int            snap [4];
  exp_t          q [4][$];
  logic [DW-1:0] mdl [NB][DEPTH];

  function automatic void chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Monitor: entries 0/1 are the registered-output banks, 2/3 the direct-Q banks.
  always @(negedge CLK) begin
    if (!RST) begin
      for (int k = 0; k < 4; k++) begin
        logic          v;
        logic [DW-1:0] d;
        int            idx;
        exp_t          e;
        idx = k % 2;
        v = (k < 2) ? rvalid1[idx] : rvalid0[idx];
        d = (k < 2) ? rdata1[idx*DW +: DW] : rdata0[idx*DW +: DW];
        if (v) rv_cnt[k]++;
        if (q[k].size() != 0 && q[k][0].due <= cyc) begin
          e = q[k].pop_front();
          chk($sformatf("rvalid_on_time k%0d due%0d", k, e.due), DW'(v), DW'(1));
          if (v) chk($sformatf("rdata k%0d due%0d", k, e.due), d, e.d);
        end else if (v) begin
          chk($sformatf("rvalid_unexpected k%0d cyc%0d", k, cyc), DW'(v), DW'(0));
        end
      end
    end
  end

  task automatic push(input int b, input logic [DW-1:0] e);
    q[b].push_back('{d: e, due: cyc + 2});
    q[2+b].push_back('{d: e, due: cyc + 1});
  endtask

  task automatic rd_exp(input int b, input int a, input logic [DW-1:0] e);
    req_valid[b] = 1'b1;
    req_we[b] = 1'b0;
    req_addr[b*AW +: AW] = AW'(a);
    req_wmask[b*MW +: MW] = '0;
    push(b, e);
  endtask

  task automatic rd(input int b, input int a);
    rd_exp(b, a, mdl[b][a]);
  endtask

  task automatic wr(input int b, input int a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    req_valid[b] = 1'b1;
    req_we[b] = 1'b1;
    req_addr[b*AW +: AW] = AW'(a);
    req_wdata[b*DW +: DW] = d;
    req_wmask[b*MW +: MW] = m;
    for (int i = 0; i < MW; i++) begin
      if (m[i]) mdl[b][a][i*8 +: 8] = d[i*8 +: 8];
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    req_valid = '0;
  endtask

  task automatic zero_model();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) mdl[b][a] = '0;
  endtask

  // Counts rising edges until init_done is seen, bounded.
  task automatic wait_init(input string nm);
    int n;
    n = 0;
    while (n < 400) begin
      @(posedge CLK);
      n++;
      #1;
      if (init_done1) break;
    end
    chk(nm, DW'(n), DW'(256));
    chk({nm, "_oreg0"}, DW'(init_done0), DW'(1));
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    zero_model();
    for (int k = 0; k < 4; k++) rv_cnt[k] = 0;

    repeat (3) @(negedge CLK);
    chk("rst_init_done", DW'(init_done1), DW'(0));
    chk("rst_req_ready", DW'(req_ready1), DW'(0));
    chk("rst_rvalid", DW'(rvalid1), DW'(0));
    chk("rst_rdata", rdata1[DW-1:0], '0);
    chk("rst_req_ready_oreg0", DW'(req_ready0), DW'(0));

    RST = 1'b0;
    wait_init("init_after_rst");
    chk("run_req_ready", DW'(req_ready1), DW'(2'b11));
    chk("run_req_ready_oreg0", DW'(req_ready0), DW'(2'b11));

    // Cleared contents after power-up.
    rd(0, 0);   rd(1, 0);   tick();
    rd(0, 17);  rd(1, 17);  tick();
    rd(0, 255); rd(1, 255); tick();

    // Byte-mask merge: only byte 0 takes the second write.
    wr(0, 3, {16{8'hA5}}, 16'hFFFF); tick();
    wr(0, 3, {16{8'h5A}}, 16'h0001); tick();
    rd_exp(0, 3, {{15{8'hA5}}, 8'h5A}); tick();

    for (int i = 0; i < 64; i++) begin
      wr(0, i, {16{8'(i)}}, 16'hFFFF);
      wr(1, i, {4{32'(i) * 32'h0101_0101 ^ 32'hDEAD_BEEF}}, 16'hFFFF);
      tick();
    end

    // Back-to-back reads on both banks.
    for (int k = 0; k < 4; k++) snap[k] = rv_cnt[k];
    for (int i = 0; i < 64; i++) begin
      rd(0, i);
      rd(1, 63 - i);
      tick();
      if (i == 32) chk("b2b_ready", DW'(req_ready1), DW'(2'b11));
    end
    repeat (4) tick();
    for (int k = 0; k < 4; k++) chk($sformatf("b2b_count k%0d", k), DW'(rv_cnt[k] - snap[k]), DW'(64));

    // Zero-mask write is suppressed.
    wr(0, 7, '1, 16'h0000);
    #1 chk("ceb_masked_write", DW'(dut.g_bank[0].u_bank.w_ceb), DW'(1));
    tick();
    rd(0, 7); tick();
    repeat (3) tick();

    // clr_req coincides with a bank1 read that must still complete.
    rd(1, 9);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("clr_req_ready_drop", DW'(req_ready1), DW'(0));
    chk("clr_init_done_drop", DW'(init_done1), DW'(0));
    zero_model();
    wait_init("init_after_clr");
    rd(0, 0);   rd(1, 9);   tick();
    rd(0, 3);   rd(1, 63);  tick();
    rd(0, 7);   rd(1, 255); tick();
    repeat (3) tick();

    // Reset in the middle of a clear restarts it from address 0.
    wr(0, 5, '1, 16'hFFFF); wr(1, 200, '1, 16'hFFFF); tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    zero_model();
    repeat (100) tick();
    chk("clr_cnt_before_rst", DW'(dut.r_clr_cnt), DW'(100));
    RST = 1'b1;
    #1;
    chk("clr_cnt_after_rst", DW'(dut.r_clr_cnt), DW'(0));
    chk("init_done_in_rst", DW'(init_done1), DW'(0));
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    wait_init("init_after_mid_rst");
    rd(0, 5); rd(1, 200); tick();
    rd(0, 0); rd(1, 100); tick();
    repeat (4) tick();

    for (int k = 0; k < 4; k++) chk($sformatf("queue_empty k%0d", k), DW'(q[k].size()), DW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
